// File: rtl/demux_buffered_if.sv
// Producer/consumer bus of demux_buffered: one input stream and n buffered output channels.
// A transfer happens on any clock edge where valid and ready are both 1; valid holds until accepted.
interface demux_buffered_if #(
  parameter int Nbits = 16,
  parameter int n     = 4
);
  localparam int SW = (n > 1) ? $clog2(n) : 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [Nbits-1:0]     in_data;
  logic [SW-1:0]        in_sel;
  logic [n-1:0]         out_valid;
  logic [n-1:0]         out_ready;
  logic [n*Nbits-1:0]   out_data;
  logic [2*n-1:0]       occ;
  logic                 sel_err;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, occ, sel_err
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, occ, sel_err
  );
endinterface

// File: rtl/demux_buffered.sv
// Routes one valid/ready stream to one of n channels, each buffered by a 2-entry FIFO.
// in_ready is a function of registered fill state and in_sel only, never of out_ready.
module demux_buffered #(
  parameter int Nbits = 16,
  parameter int n     = 4
) (
  input logic             clk,
  input logic             rst_n,
  demux_buffered_if.slave bus
);
  localparam int SW = (n > 1) ? $clog2(n) : 1;
  localparam int NP = 1 << SW;

  logic [n-1:0]  full;
  logic [n-1:0]  empty;
  logic [n-1:0]  push;
  logic [n-1:0]  pop;
  logic [NP-1:0] full_pad;
  logic          sel_ok;
  logic          accept;
  logic          sel_err_q;

  // Codes beyond n-1 read as never full, so a bad select is always accepted.
  always_comb begin
    full_pad         = '0;
    full_pad[n-1:0]  = full;
  end

  always_comb begin
    sel_ok = (int'(bus.in_sel) < n);
  end

  assign bus.in_ready = ~full_pad[bus.in_sel];
  assign accept       = bus.in_valid & bus.in_ready;

  for (genvar g = 0; g < n; g++) begin : g_ch
    logic [1:0][Nbits-1:0] mem;
    logic                  wptr;
    logic                  rptr;
    logic [1:0]            cnt;

    assign full[g]  = (cnt == 2'd2);
    assign empty[g] = (cnt == 2'd0);
    assign push[g]  = accept & sel_ok & (bus.in_sel == SW'(g));
    assign pop[g]   = ~empty[g] & bus.out_ready[g];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem  <= '0;
        wptr <= 1'b0;
        rptr <= 1'b0;
        cnt  <= 2'd0;
      end else begin
        if (push[g]) begin
          mem[wptr] <= bus.in_data;
          wptr      <= ~wptr;
        end
        if (pop[g]) begin
          rptr <= ~rptr;
        end
        // Push and pop together leave the count unchanged.
        case ({push[g], pop[g]})
          2'b10:   cnt <= cnt + 2'd1;
          2'b01:   cnt <= cnt - 2'd1;
          default: cnt <= cnt;
        endcase
      end
    end

    assign bus.out_valid[g]               = ~empty[g];
    assign bus.out_data[g*Nbits +: Nbits] = mem[rptr];
    assign bus.occ[2*g +: 2]              = cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= accept & ~sel_ok;
    end
  end

  assign bus.sel_err = sel_err_q;
endmodule

// File: tb/tb_demux_buffered.sv
// Self-checking bench for demux_buffered: n=4 and n=3 instances against per-channel queue models.
`timescale 1ns/1ps
module tb_demux_buffered;
  localparam int W = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_buffered_if #(.Nbits(W), .n(4)) if4 ();
  demux_buffered_if #(.Nbits(W), .n(3)) if3 ();

  demux_buffered #(.Nbits(W), .n(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  demux_buffered #(.Nbits(W), .n(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  int checks = 0;
  int failures = 0;

  // scoreboard: one expected queue per channel
  logic [W-1:0] exp_q  [4][$];
  logic [W-1:0] exp3_q [3][$];
  logic         exp_err3 = 1'b0;

  function automatic logic [3:0] model_valid();
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = (exp_q[c].size() != 0);
    return v;
  endfunction

  function automatic logic [7:0] model_occ();
    logic [7:0] o;
    for (int c = 0; c < 4; c++) o[2*c +: 2] = 2'(exp_q[c].size());
    return o;
  endfunction

  function automatic logic [5:0] model3_occ();
    logic [5:0] o;
    for (int c = 0; c < 3; c++) o[2*c +: 2] = 2'(exp3_q[c].size());
    return o;
  endfunction

  // driver: one cycle on the n=4 instance; model updated at the edge
  task automatic cycle4(input logic v, input logic [1:0] sel, input logic [W-1:0] d,
                        input logic [3:0] rdy, output logic got_rdy, output logic exp_rdy);
    @(negedge clk);
    if4.in_valid  = v;
    if4.in_sel    = sel;
    if4.in_data   = d;
    if4.out_ready = rdy;
    #1;
    got_rdy = if4.in_ready;
    exp_rdy = (exp_q[sel].size() < 2);
    @(posedge clk);
    for (int c = 0; c < 4; c++)
      if (rdy[c] && exp_q[c].size() > 0) void'(exp_q[c].pop_front());
    if (v && exp_rdy) exp_q[sel].push_back(d);
    #1;
  endtask

  // driver: one cycle on the n=3 instance (select 3 is out of range)
  task automatic cycle3(input logic v, input logic [1:0] sel, input logic [W-1:0] d,
                        input logic [2:0] rdy, output logic got_rdy, output logic exp_rdy);
    @(negedge clk);
    if3.in_valid  = v;
    if3.in_sel    = sel;
    if3.in_data   = d;
    if3.out_ready = rdy;
    #1;
    got_rdy = if3.in_ready;
    exp_rdy = (sel >= 2'd3) ? 1'b1 : (exp3_q[sel].size() < 2);
    @(posedge clk);
    for (int c = 0; c < 3; c++)
      if (rdy[c] && exp3_q[c].size() > 0) void'(exp3_q[c].pop_front());
    if (v && exp_rdy && sel < 2'd3) exp3_q[sel].push_back(d);
    exp_err3 = v && exp_rdy && (sel == 2'd3);
    #1;
  endtask

  // occupancy can never exceed 2, and out_valid must mirror a non-zero count
  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (if4.occ[2*c +: 2] > 2'd2 || if4.out_valid[c] !== (if4.occ[2*c +: 2] != 2'd0)) begin
          failures++;
          $display("FAIL occ_invariant ch%0d got occ=%0d valid=%b", c, if4.occ[2*c +: 2], if4.out_valid[c]);
        end
      end
    end
  end

  task automatic test_reset();
    checks++;
    if (if4.out_valid !== 4'b0 || if4.occ !== 8'b0 || if4.sel_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state4 got valid=%b occ=%h err=%b exp 0/0/0", if4.out_valid, if4.occ, if4.sel_err);
    end
    checks++;
    if (if4.out_data !== 64'b0) begin
      failures++;
      $display("FAIL reset_data4 got %h exp 0", if4.out_data);
    end
    checks++;
    if (if3.out_valid !== 3'b0 || if3.occ !== 6'b0 || if3.sel_err !== 1'b0 || if3.out_data !== 48'b0) begin
      failures++;
      $display("FAIL reset_state3 got valid=%b occ=%h err=%b data=%h exp 0", if3.out_valid, if3.occ, if3.sel_err, if3.out_data);
    end
  endtask

  task automatic test_single_push();
    logic g, e;
    cycle4(1'b1, 2'd2, 16'h1111, 4'b0000, g, e);
    checks++;
    if (if4.out_valid !== 4'b0100 || if4.out_data[2*W +: W] !== 16'h1111 || if4.occ[5:4] !== 2'd1) begin
      failures++;
      $display("FAIL single_push got valid=%b data=%h occ=%0d exp 0100/1111/1", if4.out_valid, if4.out_data[2*W +: W], if4.occ[5:4]);
    end
    cycle4(1'b0, 2'd2, 16'h0, 4'b0000, g, e);
    checks++;
    if (g !== 1'b1) begin
      failures++;
      $display("FAIL single_ready got %b exp 1", g);
    end
    cycle4(1'b0, 2'd0, 16'h0, 4'b1111, g, e);
  endtask

  task automatic test_stall();
    logic g, e;
    logic [W-1:0] vals [3];
    logic [2:0] exp_g;
    vals = '{16'h000A, 16'h000B, 16'h000C};
    exp_g = 3'b011;
    for (int k = 0; k < 3; k++) begin
      cycle4(1'b1, 2'd1, vals[k], 4'b0000, g, e);
      checks++;
      if (g !== exp_g[k] || g !== e) begin
        failures++;
        $display("FAIL stall_ready k=%0d got %b exp %b", k, g, exp_g[k]);
      end
    end
    checks++;
    if (if4.occ[3:2] !== 2'd2 || if4.out_data[W +: W] !== 16'h000A) begin
      failures++;
      $display("FAIL stall_full got occ=%0d head=%h exp 2/000a", if4.occ[3:2], if4.out_data[W +: W]);
    end
    cycle4(1'b1, 2'd3, 16'h0033, 4'b0000, g, e);
    checks++;
    if (g !== 1'b1) begin
      failures++;
      $display("FAIL stall_cross got %b exp 1", g);
    end
    // pop with the channel full: the waiting 0xC is refused this cycle
    cycle4(1'b1, 2'd1, 16'h000C, 4'b0010, g, e);
    checks++;
    if (g !== 1'b0 || if4.out_data[W +: W] !== 16'h000B || if4.occ[3:2] !== 2'd1) begin
      failures++;
      $display("FAIL stall_pop1 got rdy=%b head=%h occ=%0d exp 0/000b/1", g, if4.out_data[W +: W], if4.occ[3:2]);
    end
    cycle4(1'b1, 2'd1, 16'h000C, 4'b0010, g, e);
    checks++;
    if (g !== 1'b1 || if4.out_data[W +: W] !== 16'h000C || if4.occ[3:2] !== 2'd1) begin
      failures++;
      $display("FAIL stall_pop2 got rdy=%b head=%h occ=%0d exp 1/000c/1", g, if4.out_data[W +: W], if4.occ[3:2]);
    end
    checks++;
    if (if4.occ !== model_occ() || if4.out_valid !== model_valid()) begin
      failures++;
      $display("FAIL stall_model got occ=%h valid=%b exp %h/%b", if4.occ, if4.out_valid, model_occ(), model_valid());
    end
    cycle4(1'b0, 2'd0, 16'h0, 4'b1111, g, e);
  endtask

  task automatic test_same_cycle();
    logic g, e;
    cycle4(1'b1, 2'd0, 16'h0005, 4'b0000, g, e);
    for (int k = 0; k < 8; k++) begin
      cycle4(1'b1, 2'd0, 16'(6 + k), 4'b0001, g, e);
      checks++;
      if (g !== 1'b1 || if4.out_data[W-1:0] !== 16'(6 + k) || if4.occ[1:0] !== 2'd1) begin
        failures++;
        $display("FAIL same_cycle k=%0d got rdy=%b head=%h occ=%0d exp 1/%h/1", k, g, if4.out_data[W-1:0], if4.occ[1:0], 16'(6 + k));
      end
    end
    cycle4(1'b0, 2'd0, 16'h0, 4'b1111, g, e);
  endtask

  task automatic test_sel_err();
    logic g, e;
    logic [1:0] sels [5];
    logic [4:0] exp_err;
    sels = '{2'd3, 2'd0, 2'd3, 2'd3, 2'd1};
    exp_err = 5'b01101;
    for (int k = 0; k < 5; k++) begin
      cycle3(1'b1, sels[k], 16'hDEAD + 16'(k), 3'b000, g, e);
      checks++;
      if (if3.sel_err !== exp_err[k] || g !== 1'b1) begin
        failures++;
        $display("FAIL sel_err k=%0d got err=%b rdy=%b exp %b/1", k, if3.sel_err, g, exp_err[k]);
      end
      checks++;
      if (if3.occ !== model3_occ()) begin
        failures++;
        $display("FAIL sel_occ k=%0d got %h exp %h", k, if3.occ, model3_occ());
      end
    end
    for (int k = 0; k < 60; k++) begin
      cycle3(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
             3'($urandom_range(0, 7)), g, e);
      checks++;
      if (g !== e || if3.sel_err !== exp_err3 || if3.occ !== model3_occ()) begin
        failures++;
        $display("FAIL sel_rand k=%0d got rdy=%b err=%b occ=%h exp %b/%b/%h", k, g, if3.sel_err, if3.occ, e, exp_err3, model3_occ());
      end
      for (int c = 0; c < 3; c++) begin
        if (exp3_q[c].size() > 0) begin
          checks++;
          if (if3.out_data[c*W +: W] !== exp3_q[c][0]) begin
            failures++;
            $display("FAIL sel_data ch%0d got %h exp %h", c, if3.out_data[c*W +: W], exp3_q[c][0]);
          end
        end
      end
    end
    cycle3(1'b0, 2'd0, 16'h0, 3'b111, g, e);
    cycle3(1'b0, 2'd0, 16'h0, 3'b111, g, e);
  endtask

  task automatic test_async_reset();
    logic g, e;
    cycle4(1'b1, 2'd0, 16'h0101, 4'b0000, g, e);
    cycle4(1'b1, 2'd0, 16'h0202, 4'b0000, g, e);
    cycle4(1'b1, 2'd3, 16'h0303, 4'b0000, g, e);
    cycle4(1'b1, 2'd3, 16'h0404, 4'b0000, g, e);
    checks++;
    if (if4.occ !== 8'b1000_0010) begin
      failures++;
      $display("FAIL areset_fill got occ=%h exp 82", if4.occ);
    end
    if4.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (if4.out_valid !== 4'b0 || if4.occ !== 8'b0) begin
      failures++;
      $display("FAIL areset_now got valid=%b occ=%h exp 0/0", if4.out_valid, if4.occ);
    end
    for (int c = 0; c < 4; c++) exp_q[c].delete();
    for (int c = 0; c < 3; c++) exp3_q[c].delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle4(1'b0, 2'd0, 16'h0, 4'b0000, g, e);
    checks++;
    if (if4.out_valid !== 4'b0) begin
      failures++;
      $display("FAIL areset_idle got valid=%b exp 0", if4.out_valid);
    end
    cycle4(1'b1, 2'd1, 16'h0077, 4'b0000, g, e);
    checks++;
    if (if4.out_valid !== 4'b0010 || if4.out_data[W +: W] !== 16'h0077 || if4.occ !== 8'b0000_0100) begin
      failures++;
      $display("FAIL areset_first got valid=%b data=%h occ=%h exp 0010/0077/04", if4.out_valid, if4.out_data[W +: W], if4.occ);
    end
    cycle4(1'b0, 2'd0, 16'h0, 4'b1111, g, e);
  endtask

  task automatic test_stream();
    logic g, e;
    logic [W-1:0] d;
    for (int k = 0; k < 16; k++) begin
      d = 16'($urandom);
      cycle4(1'b1, 2'(k % 4), d, 4'b1111, g, e);
      checks++;
      if (g !== 1'b1 || if4.out_valid[k % 4] !== 1'b1 || if4.out_data[(k % 4)*W +: W] !== d) begin
        failures++;
        $display("FAIL stream k=%0d got rdy=%b valid=%b data=%h exp 1/1/%h", k, g, if4.out_valid[k % 4], if4.out_data[(k % 4)*W +: W], d);
      end
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (if4.occ[2*c +: 2] > 2'd1) begin
          failures++;
          $display("FAIL stream_occ k=%0d ch%0d got %0d exp <=1", k, c, if4.occ[2*c +: 2]);
        end
      end
    end
    cycle4(1'b0, 2'd0, 16'h0, 4'b1111, g, e);
  endtask

  task automatic test_random();
    logic g, e;
    for (int k = 0; k < 300; k++) begin
      cycle4(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
             4'($urandom_range(0, 15)), g, e);
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL rand_ready k=%0d got %b exp %b", k, g, e);
      end
      checks++;
      if (if4.out_valid !== model_valid() || if4.occ !== model_occ()) begin
        failures++;
        $display("FAIL rand_state k=%0d got valid=%b occ=%h exp %b/%h", k, if4.out_valid, if4.occ, model_valid(), model_occ());
      end
      for (int c = 0; c < 4; c++) begin
        if (exp_q[c].size() > 0) begin
          checks++;
          if (if4.out_data[c*W +: W] !== exp_q[c][0]) begin
            failures++;
            $display("FAIL rand_data k=%0d ch%0d got %h exp %h", k, c, if4.out_data[c*W +: W], exp_q[c][0]);
          end
        end
      end
    end
  endtask

  initial begin
    if4.in_valid = 1'b0; if4.in_sel = '0; if4.in_data = '0; if4.out_ready = '0;
    if3.in_valid = 1'b0; if3.in_sel = '0; if3.in_data = '0; if3.out_ready = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_reset();
    test_single_push();
    test_stall();
    test_same_cycle();
    test_sel_err();
    test_async_reset();
    test_stream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
